// File: rtl/sram_pkg.sv
// Shared types for the SRAM bus arbiter: FSM state encoding and owner constants.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant selection between fetch and load/store requests.
// With ARB_ROUND_ROBIN_EN defined a tie goes to the side not served last; otherwise data wins.
module sram_arb_grant
    import sram_pkg::*;
(
    input  logic       inst_req_i,
    input  logic       data_req_i,
    input  logic [1:0] mask_i,      // bit0 fetch, bit1 data: side that just completed
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       last_i,
`endif
    output logic       valid_o,
    output logic       own_o
);

    logic inst_v;
    logic data_v;

    always_comb begin
        inst_v  = inst_req_i & ~mask_i[0];
        data_v  = data_req_i & ~mask_i[1];
        valid_o = inst_v | data_v;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_v && data_v) begin
            own_o = ~last_i;
        end else begin
            own_o = data_v ? OWN_DATA : OWN_INST;
        end
`else
        own_o = data_v ? OWN_DATA : OWN_INST;
`endif
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, one transaction at a time.
// Optional round-robin tie break via ARB_ROUND_ROBIN_EN (default: data side has priority).
//   state | meaning
//   IDLE  | pick a requester, latch its request into the bus registers
//   ADDR  | bus_req high, waiting for bus_addr_ok
//   DATA  | waiting for bus_data_ok
//   DONE  | one-cycle done pulse to the owner
module sram_bus_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_done,
    output logic                inst_stall,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_sel,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_done,
    output logic                data_stall,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int SEL_W = DATA_W / 8;

    state_e              state_q;
    logic                own_q;
    logic [1:0]          mask_q;
    logic                bus_req_q;
    logic                bus_wr_q;
    logic [SEL_W-1:0]    bus_sel_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic                inst_done_q;
    logic                data_done_q;
    logic [DATA_W-1:0]   inst_rdata_q;
    logic [DATA_W-1:0]   data_rdata_q;
    logic                grant_valid;
    logic                grant_own;
    logic                finish;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_q;
`endif

    sram_arb_grant u_grant (
        .inst_req_i (inst_req),
        .data_req_i (data_req),
        .mask_i     (mask_q),
`ifdef ARB_ROUND_ROBIN_EN
        .last_i     (last_q),
`endif
        .valid_o    (grant_valid),
        .own_o      (grant_own)
    );

    // data_ok only counts in DATA, or in ADDR together with addr_ok
    always_comb begin
        finish = ((state_q == ADDR) && bus_addr_ok && bus_data_ok) ||
                 ((state_q == DATA) && bus_data_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            own_q        <= OWN_INST;
            mask_q       <= 2'b00;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q       <= OWN_INST;
`endif
        end else begin
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            mask_q      <= 2'b00;
            if (finish) begin
                state_q <= DONE;
                if (own_q == OWN_DATA) begin
                    data_rdata_q <= bus_rdata;
                    data_done_q  <= 1'b1;
                end else begin
                    inst_rdata_q <= bus_rdata;
                    inst_done_q  <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q   <= ADDR;
                        own_q     <= grant_own;
                        bus_req_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q    <= grant_own;
`endif
                        if (grant_own == OWN_DATA) begin
                            bus_wr_q    <= data_wr;
                            bus_sel_q   <= data_sel;
                            bus_addr_q  <= data_addr;
                            bus_wdata_q <= data_wdata;
                        end else begin
                            bus_wr_q    <= 1'b0;
                            bus_sel_q   <= {SEL_W{1'b1}};
                            bus_addr_q  <= inst_addr;
                            bus_wdata_q <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req_q <= 1'b0;
                        if (!bus_data_ok) begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                end
                DONE: begin
                    state_q <= IDLE;
                    mask_q  <= (own_q == OWN_DATA) ? 2'b10 : 2'b01;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_sel    = bus_sel_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_done  = inst_done_q;
    assign data_done  = data_done_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_stall = inst_req & ~inst_done_q;
    assign data_stall = data_req & ~data_done_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed plus randomized transaction-level checks of sram_bus_arbiter.
module tb_sram_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          inst_done;
    logic          inst_stall;
    logic          data_req;
    logic          data_wr;
    logic [SW-1:0] data_sel;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_done;
    logic          data_stall;
    logic          bus_req;
    logic          bus_wr;
    logic [SW-1:0] bus_sel;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: held read data per side and the side served last
    logic [DW-1:0] exp_inst_rdata;
    logic [DW-1:0] exp_data_rdata;
    logic          last_served;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_done   (inst_done),
        .inst_stall  (inst_stall),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_sel    (data_sel),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .data_stall  (data_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_sel     (bus_sel),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_bus_req"}, bus_req, 1'b0);
        check({tag, "_bus_wr"}, bus_wr, 1'b0);
        check({tag, "_bus_sel"}, bus_sel, '0);
        check({tag, "_bus_addr"}, bus_addr, '0);
        check({tag, "_bus_wdata"}, bus_wdata, '0);
        check({tag, "_dones"}, {inst_done, data_done}, 2'b00);
        check({tag, "_inst_rdata"}, inst_rdata, '0);
        check({tag, "_data_rdata"}, data_rdata, '0);
    endtask

    function automatic logic owner_stall(input logic side);
        return side ? data_stall : inst_stall;
    endfunction

    // Acts as the slave for one transaction; called in the first ADDR cycle, returns in DONE.
    task automatic run_txn(input logic side, input int ad, input bit spur, input bit comb,
                           input int dd, input logic [DW-1:0] rd);
        check("addr_phase_req", bus_req, 1'b1);
        check("addr_phase_stall", owner_stall(side), 1'b1);
        if (side) begin
            check("bus_wr_data", bus_wr, data_wr);
            check("bus_sel_data", bus_sel, data_sel);
            check("bus_addr_data", bus_addr, data_addr);
            check("bus_wdata_data", bus_wdata, data_wdata);
        end else begin
            check("bus_wr_inst", bus_wr, 1'b0);
            check("bus_sel_inst", bus_sel, {SW{1'b1}});
            check("bus_addr_inst", bus_addr, inst_addr);
        end
        for (int i = 0; i < ad; i++) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = spur;
            bus_rdata   = $urandom;
            tick();
            check("bus_req_hold", bus_req, 1'b1);
            check("no_early_done", {inst_done, data_done}, 2'b00);
        end
        bus_addr_ok = 1'b1;
        bus_data_ok = comb;
        bus_rdata   = comb ? rd : $urandom;
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        check("bus_req_drop", bus_req, 1'b0);
        if (!comb) begin
            check("data_phase_no_done", {inst_done, data_done}, 2'b00);
            check("data_phase_stall", owner_stall(side), 1'b1);
            for (int i = 0; i < dd; i++) begin
                bus_rdata = $urandom;
                tick();
                check("data_wait_no_done", {inst_done, data_done}, 2'b00);
            end
            bus_data_ok = 1'b1;
            bus_rdata   = rd;
            tick();
            bus_data_ok = 1'b0;
        end
        if (side) exp_data_rdata = rd;
        else      exp_inst_rdata = rd;
        last_served = side;
        check("done_pulse", {inst_done, data_done}, side ? 2'b01 : 2'b10);
        check("inst_rdata", inst_rdata, exp_inst_rdata);
        check("data_rdata", data_rdata, exp_data_rdata);
        check("done_stall_low", owner_stall(side), 1'b0);
    endtask

    // From DONE: one masked IDLE cycle with the request still high, then the requester drops it.
    task automatic finish_side(input logic side);
        bus_addr_ok = 1'($urandom_range(0, 1));
        bus_data_ok = 1'($urandom_range(0, 1));
        tick();
        check("idle_after_done_req", bus_req, 1'b0);
        check("idle_after_done_pulse", {inst_done, data_done}, 2'b00);
        bus_addr_ok = 1'($urandom_range(0, 1));
        bus_data_ok = 1'($urandom_range(0, 1));
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (side) data_req = 1'b0;
        else      inst_req = 1'b0;
    endtask

    // Requests are raised in an IDLE cycle; the second transaction (if any) gets random slave timing.
    task automatic do_round(input bit ireq, input bit dreq, input int ad, input bit spur,
                            input bit comb, input int dd, input logic [DW-1:0] rd);
        logic first;
        inst_req = ireq;
        data_req = dreq;
        #1;
        check("req_cycle_inst_stall", inst_stall, ireq);
        check("req_cycle_data_stall", data_stall, dreq);
        if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            first = ~last_served;
`else
            first = 1'b1;
`endif
        end else begin
            first = dreq;
        end
        tick();
        run_txn(first, ad, spur, comb, dd, rd);
        finish_side(first);
        if (ireq && dreq) begin
            run_txn(~first, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom);
            finish_side(~first);
        end
    endtask

    task automatic randomize_fields();
        inst_addr  = $urandom & 32'hFFFF_FFFC;
        data_wr    = 1'($urandom_range(0, 1));
        data_sel   = 4'($urandom_range(1, 15));
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0;  inst_addr = '0;
        data_req = 1'b0;  data_wr = 1'b0;  data_sel = '0;  data_addr = '0;  data_wdata = '0;
        bus_addr_ok = 1'b0;  bus_data_ok = 1'b0;  bus_rdata = '0;
        exp_inst_rdata = '0;  exp_data_rdata = '0;  last_served = 1'b0;
        tick();
        tick();
        check_reset_outs("reset");
        check("reset_inst_stall", inst_stall, 1'b0);
        check("reset_data_stall", data_stall, 1'b0);
        rst = 1'b0;
        tick();

        // single fetch at minimum latency
        inst_addr = 32'hBFC0_0000;
        do_round(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h3C1A_0000);

        // store
        data_wr = 1'b1;  data_sel = 4'b0011;  data_addr = 32'h8000_0004;  data_wdata = 32'hDEAD_BEEF;
        do_round(1'b0, 1'b1, 1, 1'b0, 1'b0, 1, $urandom);

        // simultaneous requests, twice
        for (int r = 0; r < 2; r++) begin
            randomize_fields();
            do_round(1'b1, 1'b1, 0, 1'b0, 1'b0, 0, $urandom);
        end

        // slow addr_ok with spurious data_ok in ADDR
        inst_addr = 32'h0000_1000;
        do_round(1'b1, 1'b0, 4, 1'b1, 1'b0, 0, 32'h1234_5678);

        // combined handshake on a load
        data_wr = 1'b0;  data_sel = 4'hF;  data_addr = 32'h8000_0010;
        do_round(1'b0, 1'b1, 0, 1'b0, 1'b1, 0, 32'hCAFE_F00D);

        // reset during DATA, then a late data_ok
        inst_addr = 32'h0000_2000;
        inst_req  = 1'b1;
        tick();
        check("rst_txn_addr", bus_req, 1'b1);
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rst = 1'b1;
        inst_req = 1'b0;
        tick();
        rst = 1'b0;
        exp_inst_rdata = '0;  exp_data_rdata = '0;  last_served = 1'b0;
        check_reset_outs("midrst");
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h5555_AAAA;
        tick();
        bus_data_ok = 1'b0;
        check("late_ok_no_done", {inst_done, data_done}, 2'b00);
        check("late_ok_inst_rdata", inst_rdata, '0);
        check("late_ok_bus_req", bus_req, 1'b0);
        tick();
        check("late_ok_no_done2", {inst_done, data_done}, 2'b00);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            int pat;
            pat = $urandom_range(1, 3);
            randomize_fields();
            do_round(pat[0], pat[1], $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                check("gap_idle", bus_req, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
